multicycle_adder: RTL and testbench
===================================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits summed per clock; WIDTH % CHUNK == 0, CHUNK >= 1; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-008 SHALL have port cin  input  1  carry-in (add) / borrow-in (sub).
REQ-009 SHALL have port lhs  input  WIDTH  left operand.
REQ-010 SHALL have port rhs  input  WIDTH  right operand.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port out  output  WIDTH  sum/difference.
REQ-014 SHALL have port cout  output  1  carry out of MSB.
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE), out_valid = (state == DONE).
REQ-017 Acceptance SHALL occur on an edge with state IDLE and in_valid = 1; it latches lhs, rhs^{WIDTH{sub}}, carry0 = cin ^ sub, sub; clears chunk index; sets state to BUSY.
REQ-018 Inputs lhs/rhs/cin/sub SHALL be sampled only at acceptance; changes at other times are ignored.
REQ-019 In BUSY, each edge SHALL add one CHUNK slice, LSB slice first, with carry from the previous slice, and write the slice into the result register.
REQ-020 After slice NCH-1 is added, state SHALL become DONE; out_valid is high exactly NCH cycles after the accepting edge; CHUNK == WIDTH gives latency 1.
REQ-021 Result semantics: add -> {cout,out} = lhs + rhs + cin; sub -> out = lhs - rhs - cin mod 2^WIDTH, with cout = 1 meaning no borrow.
REQ-022 ovf SHALL be 1 iff lhs[MSB] == effective rhs[MSB] (after inversion) and out[MSB] differs from them.
REQ-023 In DONE, out, cout and ovf SHALL hold stable until the out handshake; in_valid is ignored.
REQ-024 On an edge with DONE and out_ready = 1, state SHALL become IDLE; in_ready rises the following cycle; no input is accepted on that same edge.
REQ-025 out_ready in IDLE or BUSY SHALL have no effect.
REQ-026 out, cout and ovf SHALL be meaningful only while out_valid = 1; intermediate slice values may be visible during BUSY.

Reset
REQ-027 reset = 1 on an edge SHALL force IDLE, clear chunk index, carry, out, cout and ovf to 0, and override any concurrent handshake.
REQ-028 After reset, in_ready = 1 and out_valid = 0 from the next cycle.
REQ-029 reset asserted during BUSY or DONE SHALL discard the operation in progress; no out_valid pulse follows.

Verification
REQ-030 WIDTH=2, CHUNK=1: cin=1, lhs=1, rhs=3, sub=0 accepted -> out_valid 2 cycles later; out=1, cout=1, ovf=0.
REQ-031 WIDTH=8, CHUNK=2: lhs=0x7F, rhs=0x01, cin=0, sub=0 -> out_valid 4 cycles after accept; out=0x80, cout=0, ovf=1.
REQ-032 WIDTH=8, CHUNK=2: lhs=0x05, rhs=0x07, cin=0, sub=1 -> out=0xFE, cout=0, ovf=0; lhs=0xFF, rhs=0xFF, cin=1, sub=0 -> out=0xFF, cout=1, ovf=0.
REQ-033 Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> out_valid, out, cout and ovf held; in_ready=0; the new operands are not accepted until 1 cycle after out_ready=1.
REQ-034 Reset mid-BUSY (WIDTH=8, CHUNK=2, after slice 2): reset pulse -> next cycle in_ready=1, out_valid=0, out=0; the following operation 0x10+0x20 gives out=0x30 after 4 cycles.
REQ-035 Back-to-back: 3 operations with in_valid and out_ready held high -> each result NCH cycles after its accept; accepts spaced NCH+2 cycles apart.

Source files
------------

// File: rtl/multicycle_adder.sv
// Multicycle adder/subtractor: sums CHUNK bits per clock, LSB slice first,
// with a valid/ready handshake on both the operand and the result side.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] lhs_q, lhs_d;
  logic [WIDTH-1:0] rhs_q, rhs_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] slice_a, slice_b;
  logic [CHUNK:0]   slice_sum;

  // Handshake flags and result decode straight from registered state.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Next-state logic: accept operands, add one slice per BUSY cycle, release on handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    lhs_d     = lhs_q;
    rhs_d     = rhs_q;
    out_d     = out_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    base      = 32'(idx_q) * 32'(CHUNK);
    slice_a   = CHUNK'(lhs_q >> base);
    slice_b   = CHUNK'(rhs_q >> base);
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + (CHUNK+1)'(carry_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is lhs + ~rhs + ~borrow; sub is folded into the
          // captured operand and carry, so it need not be kept afterwards.
          lhs_d   = lhs;
          rhs_d   = rhs ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        out_d   = (out_q & ~(SLICE_MASK << base)) |
                  (WIDTH'(slice_sum[CHUNK-1:0]) << base);
        carry_d = slice_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_sum[CHUNK];
          // Signed overflow: operands agree in sign, result sign differs.
          ovf_d   = (lhs_q[WIDTH-1] == rhs_q[WIDTH-1]) &&
                    (slice_sum[CHUNK-1] != lhs_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over any concurrent handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Randomized self-checking bench: an 8-bit/2-bit-chunk adder plus a
// 2-bit/1-bit-chunk adder, both checked against an arithmetic model.
module tb_multicycle_adder;

  logic       clk, rst;
  // WIDTH=8, CHUNK=2 instance
  logic       iv, ir, sb, ci, ov, ordy, co, of;
  logic [7:0] l, r, o;
  // WIDTH=2, CHUNK=1 instance
  logic       b_iv, b_ir, b_sb, b_ci, b_ov, b_ordy, b_co, b_of;
  logic [1:0] b_l, b_r, b_o;

  int total = 0;
  int bad   = 0;

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir), .sub(sb), .cin(ci),
    .lhs(l), .rhs(r), .out_valid(ov), .out_ready(ordy), .out(o), .cout(co), .ovf(of)
  );

  multicycle_adder #(.WIDTH(2), .CHUNK(1)) u_dut2 (
    .clk(clk), .reset(rst), .in_valid(b_iv), .in_ready(b_ir), .sub(b_sb), .cin(b_ci),
    .lhs(b_l), .rhs(b_r), .out_valid(b_ov), .out_ready(b_ordy), .out(b_o), .cout(b_co), .ovf(b_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: true integer arithmetic, then reduce to WIDTH bits.
  function automatic void model(input int w, input logic s, input logic c,
                                input longint a, input longint b,
                                output longint eo, output longint ec, output longint ef);
    longint m, cc, raw, sa, sbv, sr;
    m   = longint'(1) << w;
    cc  = c ? 1 : 0;
    if (!s) begin
      raw = a + b + cc;
      eo  = raw % m;
      ec  = (raw >= m) ? 1 : 0;
    end else begin
      raw = a - b - cc;
      eo  = (raw + m) % m;
      ec  = (raw >= 0) ? 1 : 0;
    end
    sa  = (a >= m / 2) ? a - m : a;
    sbv = (b >= m / 2) ? b - m : b;
    sr  = s ? (sa - sbv - cc) : (sa + sbv + cc);
    ef  = (sr > m / 2 - 1 || sr < -(m / 2)) ? 1 : 0;
  endfunction

  // One transaction on the 8-bit instance, with 'hold' cycles of backpressure.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic s, input int hold);
    longint eo, ec, ef;
    int lat;
    model(8, s, c, a, b, eo, ec, ef);
    chk("idle_rdy", ir, 1);
    l = a; r = b; ci = c; sb = s; iv = 1'b1; ordy = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must not affect the result.
    iv = 1'b0; l = 8'($urandom); r = 8'($urandom); ci = 1'($urandom); sb = 1'($urandom);
    lat = 0;
    while (!ov && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4);
    chk("out", o, eo);
    chk("cout", co, ec);
    chk("ovf", of, ef);
    for (int h = 0; h < hold; h++) begin
      iv = 1'b1; l = 8'($urandom); r = 8'($urandom); ci = 1'($urandom); sb = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_vld", ov, 1);
      chk("hold_rdy", ir, 0);
      chk("hold_out", o, eo);
      chk("hold_cout", co, ec);
      chk("hold_ovf", of, ef);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("drain_vld", ov, 0);
    chk("drain_rdy", ir, 1);
    iv = 1'b0;
  endtask

  // One transaction on the 2-bit instance.
  task automatic do_op2(input logic [1:0] a, input logic [1:0] b, input logic c, input logic s);
    longint eo, ec, ef;
    int lat;
    model(2, s, c, a, b, eo, ec, ef);
    chk("w2_rdy", b_ir, 1);
    b_l = a; b_r = b; b_ci = c; b_sb = s; b_iv = 1'b1;
    @(posedge clk); #1;
    b_iv = 1'b0; b_l = 2'($urandom); b_r = 2'($urandom);
    lat = 0;
    while (!b_ov && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w2_latency", lat, 2);
    chk("w2_out", b_o, eo);
    chk("w2_cout", b_co, ec);
    chk("w2_ovf", b_of, ef);
    b_ordy = 1'b1;
    @(posedge clk); #1;
    b_ordy = 1'b0;
    chk("w2_drain", b_ov, 0);
  endtask

  initial begin
    int seen;
    int cyc, acc_n, done_n, last_acc;
    longint eo, ec, ef;
    longint q_o[$], q_c[$], q_f[$];
    int q_t[$];

    iv = 0; sb = 0; ci = 0; l = 0; r = 0; ordy = 0;
    b_iv = 0; b_sb = 0; b_ci = 0; b_l = 0; b_r = 0; b_ordy = 0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rdy", ir, 1);
    chk("rst_vld", ov, 0);
    chk("rst_out", o, 0);
    chk("rst_cout", co, 0);
    chk("rst_ovf", of, 0);
    chk("rst_w2_rdy", b_ir, 1);

    // Directed vectors
    do_op2(2'd1, 2'd3, 1'b1, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 5);

    // Reset in the middle of BUSY discards the operation
    l = 8'h33; r = 8'h44; ci = 0; sb = 0; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_rdy", ir, 1);
    chk("mid_rst_vld", ov, 0);
    chk("mid_rst_out", o, 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ov) seen = 1;
    end
    chk("mid_rst_stale", seen, 0);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, 0);

    // Back-to-back with in_valid and out_ready held high
    cyc = 0; acc_n = 0; done_n = 0; last_acc = -1;
    ordy = 1'b1;
    for (int k = 0; k < 60 && done_n < 3; k++) begin
      if (ov) begin
        if (q_t.size() == 0) chk("b2b_spurious", 1, 0);
        else begin
          chk("b2b_out", o, q_o.pop_front());
          chk("b2b_cout", co, q_c.pop_front());
          chk("b2b_ovf", of, q_f.pop_front());
          chk("b2b_lat", cyc - q_t.pop_front(), 4);
          done_n++;
        end
      end
      if (acc_n < 3) begin
        l = 8'($urandom); r = 8'($urandom); ci = 1'($urandom); sb = 1'($urandom);
        iv = 1'b1;
        if (ir) begin
          model(8, sb, ci, l, r, eo, ec, ef);
          q_o.push_back(eo); q_c.push_back(ec); q_f.push_back(ef);
          q_t.push_back(cyc + 1);
          if (last_acc >= 0) chk("b2b_gap", cyc + 1 - last_acc, 6);
          last_acc = cyc + 1;
          acc_n++;
        end
      end else begin
        iv = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_count", done_n, 3);
    ordy = 1'b0; iv = 1'b0;
    @(posedge clk); #1;

    // Random traffic
    for (int k = 0; k < 25; k++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    for (int k = 0; k < 10; k++)
      do_op2(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
